// File: rtl/conv_post_accum_pkg.sv
// Shared constants and the requantization helper used by the convolution post-processing stages.
package conv_pkg;
   localparam int CONV_SUM_W     = 21;
   localparam int CONV_ADDER_LAT = 5;
   localparam int CONV_OUT_W     = 8;

   typedef struct packed {
      logic               clip;
      logic signed [63:0] val;
   } sat_res_t;

   // Round-half-up arithmetic right shift, then clamp to a signed ow-bit range.
   // Evaluated at 64 bits so the rounding add can never wrap.
   function automatic sat_res_t sat_round(input logic signed [63:0] v,
                                          input int unsigned        sh,
                                          input int unsigned        ow);
      sat_res_t           res;
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = v;
      if (sh > 0) begin
         r = (v + (64'sd1 <<< (sh - 1))) >>> sh;
      end
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ow - 1));
      res.clip = 1'b0;
      res.val  = r;
      if (r > hi) begin
         res.clip = 1'b1;
         res.val  = hi;
      end else if (r < lo) begin
         res.clip = 1'b1;
         res.val  = lo;
      end
      return res;
   endfunction
endpackage

// File: rtl/conv_post_accum_if.sv
// Pixel output stream: valid/ready handshake carrying one signed pixel.
interface conv_post_accum_if #(
   parameter int OUT_W = 8
) ();
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] out_data;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/conv_post_accum_fifo.sv
// First-word-fall-through FIFO with occupancy count; head reads as 0 while empty.
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_rd;
   logic             do_wr;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign count = count_reg;
   assign do_rd = rd_en && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_wr = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(do_wr) - CW'(do_rd);
      end
   end
endmodule

// File: rtl/conv_post_accum.sv
// Post-adder-tree stage: aligns tree sums, accumulates channels, biases, requantizes and buffers pixels.
module conv_post_accum
   import conv_pkg::*;
#(
   parameter int SUM_W      = CONV_SUM_W,
   parameter int ADDER_LAT  = CONV_ADDER_LAT,
   parameter int N_CH       = 3,
   parameter int ACC_W      = 32,
   parameter int BIAS_W     = 16,
   parameter int OUT_W      = CONV_OUT_W,
   parameter int SHIFT      = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          win_valid,
   input  logic signed [SUM_W-1:0]       sum_in,
   input  logic signed [BIAS_W-1:0]      bias,
   input  logic                          relu_en,
   output logic                          issue_ok,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          sat_sticky,
   output logic                          ovf_sticky,
   conv_post_accum_if.master             pix
);
   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [ADDER_LAT-1:0]    vld_sr_reg;
   logic                    vld_a;
   logic [CH_W-1:0]         ch_cnt_reg;
   logic                    last_ch;
   logic signed [ACC_W-1:0] acc_reg;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] s1_reg;
   logic                    s1_vld_reg;
   logic signed [ACC_W-1:0] relu_val;
   sat_res_t                post;
   logic [OUT_W-1:0]        pix_val;
   logic                    fifo_empty;
   logic                    fifo_full;
   logic                    pop;
   logic                    drop;
   logic [31:0]             inflight;
   logic                    sat_reg;
   logic                    ovf_reg;

   // The tree has no valid of its own, so win_valid is replayed ADDER_LAT cycles later.
   for (genvar gi = 0; gi < ADDER_LAT; gi++) begin : g_vld
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            vld_sr_reg[gi] <= 1'b0;
         end else begin
            if (gi == 0) vld_sr_reg[gi] <= win_valid;
            else         vld_sr_reg[gi] <= vld_sr_reg[(gi == 0) ? 0 : gi - 1];
         end
      end
   end

   assign vld_a    = vld_sr_reg[ADDER_LAT-1];
   assign last_ch  = (ch_cnt_reg == CH_W'(N_CH - 1));
   assign acc_next = (ch_cnt_reg == '0) ? ACC_W'(sum_in) : acc_reg + ACC_W'(sum_in);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch_cnt_reg <= '0;
         acc_reg    <= '0;
         s1_reg     <= '0;
         s1_vld_reg <= 1'b0;
      end else begin
         if (vld_a) begin
            acc_reg    <= acc_next;
            ch_cnt_reg <= last_ch ? '0 : ch_cnt_reg + 1'b1;
         end
         s1_vld_reg <= vld_a && last_ch;
         if (vld_a && last_ch) begin
            s1_reg <= acc_next + ACC_W'(bias);
         end
      end
   end

   always_comb begin
      relu_val = (relu_en && s1_reg[ACC_W-1]) ? '0 : s1_reg;
      post     = sat_round(64'(relu_val), SHIFT, OUT_W);
      pix_val  = OUT_W'(post.val);
   end

   assign pop  = pix.out_valid && pix.out_ready;
   assign drop = s1_vld_reg && fifo_full && !pop;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (OUT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (s1_vld_reg),
      .wr_data (pix_val),
      .rd_en   (pop),
      .rd_data (pix.out_data),
      .empty   (fifo_empty),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign pix.out_valid = !fifo_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_reg <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         sat_reg <= sat_reg | (s1_vld_reg & post.clip);
         ovf_reg <= ovf_reg | drop;
      end
   end

   assign sat_sticky = sat_reg;
   assign ovf_sticky = ovf_reg;

   // Every window in flight is counted as a future pixel so the FIFO can never be overrun.
   always_comb begin
      inflight = {31'd0, s1_vld_reg};
      for (int i = 0; i < ADDER_LAT; i++) begin
         inflight = inflight + {31'd0, vld_sr_reg[i]};
      end
   end

   assign issue_ok = (32'(fifo_count) + inflight) < 32'(FIFO_DEPTH);
endmodule

// File: tb/tb_conv_post_accum.sv
// Scoreboard bench: two instances (SHIFT=2 and SHIFT=8) share one stimulus stream and tree model.
module tb_conv_post_accum;
   localparam int SUM_W = 21;
   localparam int OUT_W = 8;
   localparam int DEPTH = 8;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     win_valid;
   logic signed [SUM_W-1:0]  win_sum;
   logic signed [SUM_W-1:0]  sum_in;
   logic signed [15:0]       bias;
   logic                     relu_en;
   logic                     out_ready;
   logic                     issue_ok2, issue_ok8;
   logic [3:0]               cnt2, cnt8;
   logic                     sat2, sat8, ovf2, ovf8;
   logic signed [SUM_W-1:0]  pipe [0:4];

   int     n_checks = 0;
   int     n_errors = 0;
   longint q2[$];
   longint q8[$];
   longint m_acc = 0;
   int     m_ch = 0;
   bit     drop_mode = 1'b0;
   bit     saw_block = 1'b0;

   conv_post_accum_if #(.OUT_W(OUT_W)) pix2 ();
   conv_post_accum_if #(.OUT_W(OUT_W)) pix8 ();
   assign pix2.out_ready = out_ready;
   assign pix8.out_ready = out_ready;

   always #5 clk = ~clk;

   // Tree model: a window's sum appears on sum_in exactly five cycles after issue, garbage otherwise.
   always @(posedge clk) begin
      pipe[0] <= win_valid ? win_sum : SUM_W'($urandom);
      for (int k = 4; k > 0; k--) pipe[k] <= pipe[k-1];
   end
   assign sum_in = pipe[4];

   conv_post_accum #(.N_CH(3), .SHIFT(2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .sum_in(sum_in), .bias(bias),
      .relu_en(relu_en), .issue_ok(issue_ok2), .fifo_count(cnt2), .sat_sticky(sat2),
      .ovf_sticky(ovf2), .pix(pix2)
   );

   conv_post_accum #(.N_CH(3), .SHIFT(8), .FIFO_DEPTH(DEPTH)) dut8 (
      .clk(clk), .rst_n(rst_n), .win_valid(win_valid), .sum_in(sum_in), .bias(bias),
      .relu_en(relu_en), .issue_ok(issue_ok8), .fifo_count(cnt8), .sat_sticky(sat8),
      .ovf_sticky(ovf8), .pix(pix8)
   );

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model_pix(input longint s, input bit relu, input int sh);
      longint r;
      r = (relu && s < 0) ? 0 : s;
      if (sh > 0) r = (r + (longint'(1) <<< (sh - 1))) >>> sh;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_win(input longint s);
      win_valid = 1'b1;
      win_sum   = SUM_W'(s);
      m_acc     = (m_ch == 0) ? s : m_acc + s;
      if (m_ch == 2) begin
         if (!drop_mode) begin
            q2.push_back(model_pix(m_acc + longint'(bias), relu_en, 2));
            q8.push_back(model_pix(m_acc + longint'(bias), relu_en, 8));
         end
         m_ch = 0;
      end else begin
         m_ch++;
      end
      $display("issue win sum=%0d ch_next=%0d", s, m_ch);
      tick();
      win_valid = 1'b0;
   endtask

   task automatic issue_credit(input longint s);
      int n = 0;
      while (!issue_ok2 && n < 200) begin
         saw_block = 1'b1;
         tick();
         n++;
      end
      if (n >= 200) check("credit_timeout", 0, 1);
      issue_win(s);
   endtask

   task automatic drain();
      int n = 0;
      while ((cnt2 != 0 || cnt8 != 0 || q2.size() != 0 || q8.size() != 0) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("drain_timeout", 0, 1);
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Monitors pop the scoreboard whenever a pixel is handed to the consumer.
   always @(negedge clk) begin
      if (pix2.out_valid && pix2.out_ready) begin
         if (q2.size() == 0) check("unexpected_pix2", longint'(pix2.out_data), 9999);
         else begin
            $display("pix2 out=%0d exp=%0d", pix2.out_data, q2[0]);
            check("pix2", longint'(pix2.out_data), q2.pop_front());
         end
      end
      if (pix8.out_valid && pix8.out_ready) begin
         if (q8.size() == 0) check("unexpected_pix8", longint'(pix8.out_data), 9999);
         else begin
            $display("pix8 out=%0d exp=%0d", pix8.out_data, q8[0]);
            check("pix8", longint'(pix8.out_data), q8.pop_front());
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; win_valid = 1'b0; win_sum = '0; bias = '0; relu_en = 1'b0; out_ready = 1'b1;

      // 1: reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_out_valid", pix2.out_valid, 0);
      check("rst_out_data", pix2.out_data, 0);
      check("rst_issue_ok", issue_ok2, 1);
      check("rst_fifo_count", cnt2, 0);
      check("rst_sat", sat2, 0);
      check("rst_ovf", ovf2, 0);
      tick();
      rst_n = 1'b1;
      wait_cycles(8);
      check("idle_no_push", cnt2, 0);

      // 2: basic pixel and latency
      bias = 16'sd6;
      issue_win(100);
      issue_win(200);
      issue_win(-50);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 6) check("lat_t6_valid", pix2.out_valid, 0);
         if (k == 7) check("lat_t7_valid", pix2.out_valid, 1);
      end
      tick();
      drain();
      check("t2_sat2", sat2, 0);
      check("t2_sat8", sat8, 0);

      // 3: saturation and ReLU
      bias = 16'sd0;
      issue_win(100000); issue_win(100000); issue_win(100000);
      wait_cycles(10);
      drain();
      check("t3_sat2", sat2, 1);
      check("t3_sat8", sat8, 1);
      issue_win(-100000); issue_win(-100000); issue_win(-100000);
      wait_cycles(10);
      drain();
      relu_en = 1'b1;
      issue_win(-100000); issue_win(-100000); issue_win(-100000);
      wait_cycles(10);
      drain();
      relu_en = 1'b0;

      // 4: backpressure with credit honoured
      out_ready = 1'b0;
      saw_block = 1'b0;
      for (int p = 0; p < 8; p++) begin
         issue_credit(p * 16 + 1);
         issue_credit(p * 8);
         issue_credit(-3);
      end
      wait_cycles(12);
      @(negedge clk);
      check("t4_saw_block", saw_block, 1);
      check("t4_full_count", cnt2, 8);
      check("t4_issue_ok_low", issue_ok2, 0);
      check("t4_ovf", ovf2, 0);
      tick();
      out_ready = 1'b1;
      drain();
      check("t4_ovf_after", ovf2, 0);

      // 5: forced overflow drops the pixel and leaves FIFO contents intact
      out_ready = 1'b0;
      for (int p = 0; p < 8; p++) begin
         issue_credit(-p * 20);
         issue_credit(p);
         issue_credit(7);
      end
      wait_cycles(12);
      drop_mode = 1'b1;
      issue_win(400); issue_win(400); issue_win(400);
      drop_mode = 1'b0;
      wait_cycles(12);
      @(negedge clk);
      check("t5_ovf2", ovf2, 1);
      check("t5_ovf8", ovf8, 1);
      check("t5_count", cnt2, 8);
      tick();
      out_ready = 1'b1;
      drain();

      // 6: reset mid-pixel discards partial accumulation
      issue_win(50);
      issue_win(60);
      rst_n = 1'b0;
      m_ch = 0;
      m_acc = 0;
      tick();
      rst_n = 1'b1;
      wait_cycles(10);
      @(negedge clk);
      check("t6_no_output", cnt2, 0);
      check("t6_ovf_cleared", ovf2, 0);
      tick();
      issue_win(4); issue_win(4); issue_win(4);
      wait_cycles(10);
      drain();
      check("t6_sat", sat2, 0);
      check("end_q2_empty", q2.size(), 0);
      check("end_q8_empty", q8.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
